// File: rtl/clock_set_ctrl_if.sv
// Bus between the clock set controller and its surroundings: timebase
// ticks, counter status, buttons in; count enables, increments, clear,
// blink selects and mode out.
interface clock_set_ctrl_if;
  logic       tick_1hz;
  logic       tick_8hz;
  logic       sec_max;
  logic       min_max;
  logic       btn_mode;
  logic       btn_inc;
  logic       sec_cen;
  logic       min_cen;
  logic       hr_cen;
  logic       min_inc;
  logic       hr_inc;
  logic       sec_clr;
  logic       blink_hr;
  logic       blink_min;
  logic [1:0] mode;

  // Environment side: drives ticks/buttons/status, observes controls.
  modport master (
    output tick_1hz, tick_8hz, sec_max, min_max, btn_mode, btn_inc,
    input  sec_cen, min_cen, hr_cen, min_inc, hr_inc, sec_clr,
           blink_hr, blink_min, mode
  );

  // Controller side.
  modport slave (
    input  tick_1hz, tick_8hz, sec_max, min_max, btn_mode, btn_inc,
    output sec_cen, min_cen, hr_cen, min_inc, hr_inc, sec_clr,
           blink_hr, blink_min, mode
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Mode and sequencing controller for the hour/minute/second counter chain.
// RUN cascades the 1 Hz tick into count enables; SET_HR / SET_MIN freeze
// time and turn the set button into increment pulses with hold-to-repeat,
// while blinking the selected digits. Every output is a register.
module clock_set_ctrl #(
  parameter int unsigned REPEAT_DLY  = 8,
  parameter int unsigned REPEAT_RATE = 2,
  parameter int unsigned BLINK_DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  clock_set_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_e;

  localparam logic [7:0] DLY8  = 8'(REPEAT_DLY);
  localparam logic [7:0] RATE8 = 8'(REPEAT_RATE);
  localparam logic [7:0] DIV8  = 8'(BLINK_DIV);

  state_e     state_q, state_d;
  logic       btn_inc_q, btn_inc_d;       // button level one cycle ago
  logic       rpt_arm_q, rpt_arm_d;       // a press in this mode is being held
  logic       rpt_active_q, rpt_active_d; // initial delay done, now repeating
  logic [7:0] rpt_cnt_q, rpt_cnt_d;
  logic       blink_phase_q, blink_phase_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;

  logic sec_cen_q, sec_cen_d;
  logic min_cen_q, min_cen_d;
  logic hr_cen_q, hr_cen_d;
  logic min_inc_q, min_inc_d;
  logic hr_inc_q, hr_inc_d;
  logic sec_clr_q, sec_clr_d;
  logic blink_hr_q, blink_hr_d;
  logic blink_min_q, blink_min_d;

  logic       state_change;
  logic       in_set;
  logic       inc_rise;
  logic       rpt_evt;
  logic       inc_evt;
  logic [7:0] rpt_cnt_inc;
  logic [7:0] blink_cnt_inc;

  // Next-state, repeat/blink counters and next output values.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    btn_inc_d     = bus.btn_inc;
    rpt_arm_d     = rpt_arm_q;
    rpt_active_d  = rpt_active_q;
    rpt_cnt_d     = rpt_cnt_q;
    blink_phase_d = blink_phase_q;
    blink_cnt_d   = blink_cnt_q;
    rpt_evt       = 1'b0;

    state_change = bus.btn_mode;
    in_set       = (state_q != ST_RUN);
    inc_rise     = bus.btn_inc & ~btn_inc_q;

    // Counters saturate rather than wrap if a match is ever missed.
    rpt_cnt_inc   = (rpt_cnt_q   == 8'hFF) ? 8'hFF : rpt_cnt_q   + 8'd1;
    blink_cnt_inc = (blink_cnt_q == 8'hFF) ? 8'hFF : blink_cnt_q + 8'd1;

    if (state_change) begin
      unique case (state_q)
        ST_RUN:     state_d = ST_SET_HR;
        ST_SET_HR:  state_d = ST_SET_MIN;
        ST_SET_MIN: state_d = ST_RUN;
        default:    state_d = ST_RUN;
      endcase
    end

    // Hold-to-repeat: a held button only repeats if it was pressed in the
    // current mode, so a mode change disarms it until the next press.
    if (state_change || !bus.btn_inc) begin
      rpt_arm_d    = 1'b0;
      rpt_active_d = 1'b0;
      rpt_cnt_d    = 8'd0;
    end else if (inc_rise) begin
      rpt_arm_d    = 1'b1;
      rpt_active_d = 1'b0;
      rpt_cnt_d    = 8'd0;
    end else if (rpt_arm_q && bus.tick_8hz) begin
      if (!rpt_active_q && rpt_cnt_inc == DLY8) begin
        rpt_evt      = 1'b1;
        rpt_active_d = 1'b1;
        rpt_cnt_d    = 8'd0;
      end else if (rpt_active_q && rpt_cnt_inc == RATE8) begin
        rpt_evt   = 1'b1;
        rpt_cnt_d = 8'd0;
      end else begin
        rpt_cnt_d = rpt_cnt_inc;
      end
    end

    // A mode change in the same cycle swallows the increment.
    inc_evt = (inc_rise | rpt_evt) & ~state_change;

    // Blink restarts visible on every mode change and on every increment.
    if (state_change || (inc_evt && in_set)) begin
      blink_phase_d = 1'b0;
      blink_cnt_d   = 8'd0;
    end else if (bus.tick_8hz) begin
      if (blink_cnt_inc == DIV8) begin
        blink_phase_d = ~blink_phase_q;
        blink_cnt_d   = 8'd0;
      end else begin
        blink_cnt_d = blink_cnt_inc;
      end
    end

    sec_cen_d   = (state_q == ST_RUN) & bus.tick_1hz;
    min_cen_d   = (state_q == ST_RUN) & bus.tick_1hz & bus.sec_max;
    hr_cen_d    = (state_q == ST_RUN) & bus.tick_1hz & bus.sec_max & bus.min_max;
    hr_inc_d    = inc_evt & (state_q == ST_SET_HR);
    min_inc_d   = inc_evt & (state_q == ST_SET_MIN);
    sec_clr_d   = state_change & (state_q == ST_SET_MIN);
    blink_hr_d  = blink_phase_d & (state_d == ST_SET_HR);
    blink_min_d = blink_phase_d & (state_d == ST_SET_MIN);
  end

  // State and registered outputs; reset aborts any set operation silently.
  // NOTE: reset is asynchronous (in the sensitivity list) so outputs drop
  // immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      btn_inc_q     <= 1'b0;
      rpt_arm_q     <= 1'b0;
      rpt_active_q  <= 1'b0;
      rpt_cnt_q     <= 8'd0;
      blink_phase_q <= 1'b0;
      blink_cnt_q   <= 8'd0;
      sec_cen_q     <= 1'b0;
      min_cen_q     <= 1'b0;
      hr_cen_q      <= 1'b0;
      min_inc_q     <= 1'b0;
      hr_inc_q      <= 1'b0;
      sec_clr_q     <= 1'b0;
      blink_hr_q    <= 1'b0;
      blink_min_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the old values.
      state_q       <= state_d;
      btn_inc_q     <= btn_inc_d;
      rpt_arm_q     <= rpt_arm_d;
      rpt_active_q  <= rpt_active_d;
      rpt_cnt_q     <= rpt_cnt_d;
      blink_phase_q <= blink_phase_d;
      blink_cnt_q   <= blink_cnt_d;
      sec_cen_q     <= sec_cen_d;
      min_cen_q     <= min_cen_d;
      hr_cen_q      <= hr_cen_d;
      min_inc_q     <= min_inc_d;
      hr_inc_q      <= hr_inc_d;
      sec_clr_q     <= sec_clr_d;
      blink_hr_q    <= blink_hr_d;
      blink_min_q   <= blink_min_d;
    end
  end

  assign bus.sec_cen   = sec_cen_q;
  assign bus.min_cen   = min_cen_q;
  assign bus.hr_cen    = hr_cen_q;
  assign bus.min_inc   = min_inc_q;
  assign bus.hr_inc    = hr_inc_q;
  assign bus.sec_clr   = sec_clr_q;
  assign bus.blink_hr  = blink_hr_q;
  assign bus.blink_min = blink_min_q;
  assign bus.mode      = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: a table of single-cycle vectors for
// the cascade, mode cycling and conflicts, then hand sequences for
// auto-repeat, blink and asynchronous reset.
module tb_clock_set_ctrl;

  logic clk;
  logic rst;

  clock_set_ctrl_if bus_if ();

  clock_set_ctrl #(
    .REPEAT_DLY (8),
    .REPEAT_RATE(2),
    .BLINK_DIV  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Output packing: {sec_cen,min_cen,hr_cen, min_inc,hr_inc, sec_clr,
  //                  blink_hr,blink_min, mode[1:0]}
  typedef struct {
    logic       t1;
    logic       smax;
    logic       mmax;
    logic       bm;
    logic       bi;
    logic       t8;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [22];

  function automatic logic [9:0] outs();
    return {bus_if.sec_cen, bus_if.min_cen, bus_if.hr_cen,
            bus_if.min_inc, bus_if.hr_inc, bus_if.sec_clr,
            bus_if.blink_hr, bus_if.blink_min, bus_if.mode};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic apply(input logic t1, input logic smax, input logic mmax,
                       input logic bm, input logic bi, input logic t8);
    bus_if.tick_1hz = t1;
    bus_if.sec_max  = smax;
    bus_if.min_max  = mmax;
    bus_if.btn_mode = bm;
    bus_if.btn_inc  = bi;
    bus_if.tick_8hz = t8;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_if.tick_1hz = 1'b0;
    bus_if.tick_8hz = 1'b0;
    bus_if.sec_max  = 1'b0;
    bus_if.min_max  = 1'b0;
    bus_if.btn_mode = 1'b0;
    bus_if.btn_inc  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int cnt_at7;
    int cnt_at8;

    //           t1    smax  mmax  bm    bi    t8    cen inc clr blk mode
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'b111_00_0_00_00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b000_00_0_00_00};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'b110_00_0_00_00};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b000_00_0_00_00};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'b100_00_0_00_00};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b000_00_0_00_00};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'b000_00_0_00_00};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b000_00_0_00_00};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'b111_00_0_00_01};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b000_00_0_00_01};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'b000_00_0_00_01};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'b000_01_0_00_01};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'b000_00_0_00_01};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b000_00_0_00_01};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'b000_00_0_00_10};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'b000_00_0_00_10};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b000_00_0_00_10};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'b000_10_0_00_10};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b000_00_0_00_10};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'b000_00_1_00_00};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b000_00_0_00_00};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'b100_00_0_00_00};

    // Reset state
    do_reset();
    check("reset_state", outs(), 10'b0);

    // Table: cascade, mode cycling, frozen time, conflict, sec_clr
    for (int i = 0; i < 22; i++) begin
      apply(vecs[i].t1, vecs[i].smax, vecs[i].mmax, vecs[i].bm, vecs[i].bi, vecs[i].t8);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Auto-repeat in SET_HR: 16 ticks held -> 1 + 1 + 4 = 6 pulses
    do_reset();
    apply(0, 0, 0, 1, 0, 0);
    check("rpt_enter_set_hr", outs(), 10'b000_00_0_00_01);
    cnt = 0;
    cnt_at7 = 0;
    cnt_at8 = 0;
    apply(0, 0, 0, 0, 1, 0);
    check("rpt_press_pulse", {8'b0, bus_if.min_inc, bus_if.hr_inc}, 10'b01);
    cnt += int'(bus_if.hr_inc);
    for (int t = 1; t <= 16; t++) begin
      apply(0, 0, 0, 0, 1, 1);
      cnt += int'(bus_if.hr_inc);
      if (bus_if.min_inc) cnt += 100;
      if (t == 7) cnt_at7 = cnt;
      if (t == 8) cnt_at8 = cnt;
      apply(0, 0, 0, 0, 1, 0);
      cnt += int'(bus_if.hr_inc);
    end
    check("rpt_count_at_tick7", 10'(cnt_at7), 10'd1);
    check("rpt_count_at_tick8", 10'(cnt_at8), 10'd2);
    check("rpt_count_16_ticks", 10'(cnt), 10'd6);
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    cnt = 0;
    apply(0, 0, 0, 0, 1, 0);
    cnt += int'(bus_if.hr_inc);
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 0, 0, 1, 0);
      cnt += int'(bus_if.hr_inc);
    end
    check("rpt_repress_single", 10'(cnt), 10'd1);

    // Blink in SET_MIN
    do_reset();
    apply(0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    check("blink_enter_set_min", outs(), 10'b000_00_0_00_10);
    for (int t = 1; t <= 6; t++) begin
      apply(0, 0, 0, 0, 0, 1);
      check($sformatf("blink_tick%0d", t), {8'b0, bus_if.blink_hr, bus_if.blink_min},
            (t >= 4) ? 10'b01 : 10'b00);
      apply(0, 0, 0, 0, 0, 0);
    end
    apply(0, 0, 0, 0, 1, 0);
    check("blink_inc_forces_visible", outs(), 10'b000_10_0_00_10);
    apply(0, 0, 0, 0, 0, 0);
    for (int t = 1; t <= 4; t++) begin
      apply(0, 0, 0, 0, 0, 1);
      check($sformatf("blink_restart_tick%0d", t), {8'b0, bus_if.blink_hr, bus_if.blink_min},
            (t == 4) ? 10'b01 : 10'b00);
      apply(0, 0, 0, 0, 0, 0);
    end

    // Asynchronous reset mid SET_MIN, then no sec_clr after release
    do_reset();
    apply(0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    for (int t = 1; t <= 4; t++) begin
      apply(0, 0, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 0, 0);
    end
    check("rst_pre_blinking", outs(), 10'b000_00_0_01_10);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_clear", outs(), 10'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 0, 0, 0, 0);
      check($sformatf("rst_release_idle%0d", k), outs(), 10'b0);
    end
    apply(0, 0, 0, 1, 0, 0);
    check("rst_then_mode", outs(), 10'b000_00_0_00_01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
